if_stage_ctrl: RTL and testbench

//  Fetch stage plus IF/ID pipeline register; directly upstream of hazard_detection.

---
 rtl/if_stage_ctrl_if.sv | 28 ++
 rtl/if_stage_ctrl.sv | 131 +++++++++++++
 tb/tb_if_stage_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/if_stage_ctrl_if.sv
// Fetch-stage bus: synchronous imem read port plus the IF/ID register view consumed by decode/hazard logic.
// The fetch stage drives through master; memory and the ID consumer attach through slave.
interface if_stage_ctrl_if #(
  parameter int XLEN = 32
);
  logic            imem_en;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_inst;
  logic [6:0]      id_inst_op;
  logic [2:0]      id_func3_code;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;

  modport master (
    output imem_en, imem_addr,
    input  imem_rdata,
    output id_valid, id_pc, id_inst, id_inst_op, id_func3_code, id_rs1, id_rs2
  );

  modport slave (
    input  imem_en, imem_addr,
    output imem_rdata,
    input  id_valid, id_pc, id_inst, id_inst_op, id_func3_code, id_rs1, id_rs2
  );
endinterface

// File: rtl/if_stage_ctrl.sv
// Fetch PC generation + IF/ID register; 1-cycle imem, ID two cycles behind fetch.
// load_stall holds fetch/ID with a 1-entry skid (no release bubble); flush redirects with one bubble.
module if_stage_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_stall,
  input  logic             flush,
  input  logic [XLEN-1:0]  br_addr,
  if_stage_ctrl_if.master  bus,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, HOLD} state_t;

  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

  state_t          state, state_nxt;
  logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
  logic            inflight_valid, inflight_valid_nxt;
  logic [XLEN-1:0] inflight_pc, inflight_pc_nxt;
  logic            skid_valid, skid_valid_nxt;
  logic [XLEN-1:0] skid_inst, skid_inst_nxt;
  logic [XLEN-1:0] skid_pc, skid_pc_nxt;
  logic            id_valid, id_valid_nxt;
  logic [XLEN-1:0] id_pc, id_pc_nxt;
  logic [XLEN-1:0] id_inst, id_inst_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      fetch_pc       <= RESET_PC;
      inflight_valid <= 1'b0;
      inflight_pc    <= '0;
      skid_valid     <= 1'b0;
      skid_inst      <= NOP_INST;
      skid_pc        <= '0;
      id_valid       <= 1'b0;
      id_pc          <= '0;
      id_inst        <= NOP_INST;
      stall_cnt      <= '0;
      flush_cnt      <= '0;
    end else begin
      state          <= state_nxt;
      fetch_pc       <= fetch_pc_nxt;
      inflight_valid <= inflight_valid_nxt;
      inflight_pc    <= inflight_pc_nxt;
      skid_valid     <= skid_valid_nxt;
      skid_inst      <= skid_inst_nxt;
      skid_pc        <= skid_pc_nxt;
      id_valid       <= id_valid_nxt;
      id_pc          <= id_pc_nxt;
      id_inst        <= id_inst_nxt;
      if (flush && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
      if (load_stall && !flush && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt          = state;
    fetch_pc_nxt       = fetch_pc;
    inflight_valid_nxt = inflight_valid;
    inflight_pc_nxt    = inflight_pc;
    skid_valid_nxt     = skid_valid;
    skid_inst_nxt      = skid_inst;
    skid_pc_nxt        = skid_pc;
    id_valid_nxt       = id_valid;
    id_pc_nxt          = id_pc;
    id_inst_nxt        = id_inst;
    bus.imem_en        = 1'b0;
    bus.imem_addr      = fetch_pc;

    if (flush) begin
      // Redirect target goes straight to imem so the new stream starts this cycle.
      bus.imem_en        = 1'b1;
      bus.imem_addr      = br_addr;
      fetch_pc_nxt       = br_addr + PC_INC;
      inflight_valid_nxt = 1'b1;
      inflight_pc_nxt    = br_addr;
      skid_valid_nxt     = 1'b0;
      id_valid_nxt       = 1'b0;
      id_inst_nxt        = NOP_INST;
      state_nxt          = RUN;
    end else if (load_stall) begin
      // imem data only lives for one cycle, so park it on the first stall cycle.
      if (inflight_valid && !skid_valid) begin
        skid_valid_nxt = 1'b1;
        skid_inst_nxt  = bus.imem_rdata;
        skid_pc_nxt    = inflight_pc;
      end
      inflight_valid_nxt = 1'b0;
      state_nxt          = HOLD;
    end else begin
      bus.imem_en        = 1'b1;
      fetch_pc_nxt       = fetch_pc + PC_INC;
      inflight_valid_nxt = 1'b1;
      inflight_pc_nxt    = fetch_pc;
      if (state == HOLD) begin
        id_valid_nxt   = skid_valid;
        id_inst_nxt    = skid_valid ? skid_inst : NOP_INST;
        if (skid_valid)
          id_pc_nxt = skid_pc;
        skid_valid_nxt = 1'b0;
      end else begin
        id_valid_nxt = inflight_valid;
        id_pc_nxt    = inflight_pc;
        id_inst_nxt  = inflight_valid ? bus.imem_rdata : NOP_INST;
      end
      state_nxt = RUN;
    end

    if (rst)
      bus.imem_en = 1'b0;
  end

  assign bus.id_valid      = id_valid;
  assign bus.id_pc         = id_pc;
  assign bus.id_inst       = id_inst;
  assign bus.id_inst_op    = id_inst[6:0];
  assign bus.id_func3_code = id_inst[14:12];
  assign bus.id_rs1        = id_inst[19:15];
  assign bus.id_rs2        = id_inst[24:20];

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Directed bench for if_stage_ctrl: reset, streaming, stall/skid, flush, flush-over-stall, wrap, saturation, reset in HOLD.
module tb_if_stage_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        load_stall;
  logic        flush;
  logic [31:0] br_addr;
  logic [3:0]  stall_cnt;
  logic [3:0]  flush_cnt;
  int          total = 0;
  int          bad   = 0;
  logic [31:0] tmp;

  if_stage_ctrl_if #(.XLEN(32)) bus ();

  if_stage_ctrl #(
    .XLEN(32), .RESET_PC(32'h0), .NOP_INST(32'h0000_0013), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .load_stall(load_stall), .flush(flush), .br_addr(br_addr),
    .bus(bus.master), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    inst_of = {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Synchronous imem; returns junk when not enabled so a lost skid capture shows up.
  always @(posedge clk)
    bus.imem_rdata <= bus.imem_en ? inst_of(bus.imem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_id(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'b0, bus.id_valid}, 32'h1);
    chk({tag, "_pc"}, bus.id_pc, pc);
    chk({tag, "_inst"}, bus.id_inst, inst_of(pc));
  endtask

  initial begin
    rst = 1'b1; load_stall = 1'b0; flush = 1'b0; br_addr = '0;
    cyc(); cyc();
    // reset state
    chk("rst_id_valid", {31'b0, bus.id_valid}, 32'h0);
    chk("rst_id_inst", bus.id_inst, 32'h13);
    chk("rst_id_pc", bus.id_pc, 32'h0);
    chk("rst_stall_cnt", {28'b0, stall_cnt}, 32'h0);
    chk("rst_flush_cnt", {28'b0, flush_cnt}, 32'h0);
    chk("rst_imem_en", {31'b0, bus.imem_en}, 32'h0);

    // streaming from RESET_PC
    rst = 1'b0; #1;
    chk("run_en0", {31'b0, bus.imem_en}, 32'h1);
    chk("run_addr0", bus.imem_addr, 32'h0);
    cyc();
    chk("run_addr4", bus.imem_addr, 32'h4);
    chk("run_bubble", {31'b0, bus.id_valid}, 32'h0);
    cyc();
    chk_id("run_id0", 32'h0);
    chk("run_addr8", bus.imem_addr, 32'h8);
    cyc(); chk_id("run_id4", 32'h4);
    cyc(); chk_id("run_id8", 32'h8);
    cyc(); chk_id("run_idC", 32'hC);

    // 3-cycle stall with 0x10 in flight
    load_stall = 1'b1; #1;
    chk("stall_en", {31'b0, bus.imem_en}, 32'h0);
    cyc(); cyc();
    chk("stall_hold_pc", bus.id_pc, 32'hC);
    cyc();
    chk("stall_hold_pc2", bus.id_pc, 32'hC);
    chk("stall_cnt3", {28'b0, stall_cnt}, 32'h3);
    load_stall = 1'b0; #1;
    chk("rel_en", {31'b0, bus.imem_en}, 32'h1);
    chk("rel_addr", bus.imem_addr, 32'h14);
    cyc();
    chk_id("rel_id10", 32'h10);
    tmp = inst_of(32'h10);
    chk("dec_op", {25'b0, bus.id_inst_op}, {25'b0, tmp[6:0]});
    chk("dec_f3", {29'b0, bus.id_func3_code}, {29'b0, tmp[14:12]});
    chk("dec_rs1", {27'b0, bus.id_rs1}, {27'b0, tmp[19:15]});
    chk("dec_rs2", {27'b0, bus.id_rs2}, {27'b0, tmp[24:20]});
    cyc();
    chk_id("rel_id14", 32'h14);

    // flush to 0x100
    flush = 1'b1; br_addr = 32'h100; #1;
    chk("fl_en", {31'b0, bus.imem_en}, 32'h1);
    chk("fl_addr", bus.imem_addr, 32'h100);
    cyc();
    flush = 1'b0; #1;
    chk("fl_bubble_valid", {31'b0, bus.id_valid}, 32'h0);
    chk("fl_bubble_inst", bus.id_inst, 32'h13);
    chk("fl_cnt1", {28'b0, flush_cnt}, 32'h1);
    chk("fl_next_addr", bus.imem_addr, 32'h104);
    cyc();
    chk_id("fl_id100", 32'h100);
    chk("fl_stall_cnt", {28'b0, stall_cnt}, 32'h3);

    // stall with skid filled, then flush+stall together
    load_stall = 1'b1;
    cyc(); cyc();
    chk("hs_hold_pc", bus.id_pc, 32'h100);
    flush = 1'b1; br_addr = 32'h200; #1;
    chk("hs_addr", bus.imem_addr, 32'h200);
    chk("hs_en", {31'b0, bus.imem_en}, 32'h1);
    cyc();
    flush = 1'b0; load_stall = 1'b0; #1;
    chk("hs_bubble", {31'b0, bus.id_valid}, 32'h0);
    chk("hs_stall_cnt", {28'b0, stall_cnt}, 32'h5);
    chk("hs_flush_cnt", {28'b0, flush_cnt}, 32'h2);
    cyc();
    chk_id("hs_id200", 32'h200);
    cyc();
    chk_id("hs_id204", 32'h204);

    // PC wrap
    flush = 1'b1; br_addr = 32'hFFFF_FFFC;
    cyc();
    flush = 1'b0; #1;
    chk("wrap_addr", bus.imem_addr, 32'h0);
    cyc();
    chk_id("wrap_idtop", 32'hFFFF_FFFC);
    cyc();
    chk_id("wrap_id0", 32'h0);

    // stall counter saturation
    load_stall = 1'b1;
    repeat (20) cyc();
    chk("sat_stall_cnt", {28'b0, stall_cnt}, 32'hF);
    chk("sat_flush_cnt", {28'b0, flush_cnt}, 32'h3);

    // reset during HOLD
    rst = 1'b1;
    cyc();
    chk("hrst_id_valid", {31'b0, bus.id_valid}, 32'h0);
    chk("hrst_id_inst", bus.id_inst, 32'h13);
    chk("hrst_stall_cnt", {28'b0, stall_cnt}, 32'h0);
    chk("hrst_flush_cnt", {28'b0, flush_cnt}, 32'h0);
    chk("hrst_en", {31'b0, bus.imem_en}, 32'h0);
    rst = 1'b0; load_stall = 1'b0; #1;
    chk("hrst_addr", bus.imem_addr, 32'h0);
    cyc(); cyc();
    chk_id("hrst_id0", 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
